// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared state, opcode, funct and control-field encodings for the multicycle sequencer
package multicycle_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXEC   = 4'd6;
  localparam state_t S_ALUWB  = 4'd7;
  localparam state_t S_BRANCH = 4'd8;
  localparam state_t S_ADDIEX = 4'd9;
  localparam state_t S_ADDIWB = 4'd10;
  localparam state_t S_JUMP   = 4'd11;
  localparam state_t S_JR     = 4'd12;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLT = 5'b00100;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RD1    = 2'b11;
endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps an R-type funct field to an ALU operation and flags the arithmetic functs it knows
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_control,
  output logic       valid
);
  assign alu_control = funct == F_SUB ? ALU_SUB :
                       funct == F_AND ? ALU_AND :
                       funct == F_OR  ? ALU_OR  :
                       funct == F_SLT ? ALU_SLT : ALU_ADD;
  assign valid = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: state sequencer driving every datapath enable and select of the multicycle CPU
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic        clock,
  input  logic        resetN,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [4:0]  aluControl,
  output logic        regWrite,
  output logic [1:0]  regDst,
  output logic [1:0]  memToReg,
  output logic [1:0]  pcSrc,
  output logic        illegalOp,
  output logic [31:0] retired
);
  state_t state, next_state, decode_target;
  logic [4:0] funct_ctrl;
  logic funct_ok, is_r, retire;
  alu_decoder u_alu_decoder (.funct(funct), .alu_control(funct_ctrl), .valid(funct_ok));
  assign is_r = opcode == OP_R;
  // S_FETCH here means the instruction is unsupported and gets dropped
  assign decode_target = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                         (is_r && funct == F_JR)              ? S_JR     :
                         (is_r && funct_ok)                   ? S_EXEC   :
                         opcode == OP_BEQ                     ? S_BRANCH :
                         opcode == OP_ADDI                    ? S_ADDIEX :
                         (opcode == OP_J || opcode == OP_JAL) ? S_JUMP   : S_FETCH;
  assign retire = state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_JR} ||
                  (state == S_MEMWR && memReady);
  // next-state selection; memory states stall until memReady
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = memReady ? S_DECODE : S_FETCH;
      S_DECODE: next_state = decode_target;
      S_MEMADR: next_state = opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = memReady ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end
  // state register and retired-instruction counter
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= S_FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (retire) retired <= retired + 32'd1;
    end
  end
  // per-state control decode; everything is held at 0 while reset is asserted
  always_comb begin
    pcWrite = 1'b0;
    iorD = 1'b0;
    memRead = 1'b0;
    memWrite = 1'b0;
    irWrite = 1'b0;
    aluSrcA = 1'b0;
    aluSrcB = SRCB_B;
    aluControl = ALU_ADD;
    regWrite = 1'b0;
    regDst = DST_RT;
    memToReg = WB_ALU;
    pcSrc = PC_ALU;
    illegalOp = 1'b0;
    if (resetN) begin
      case (state)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = SRCB_FOUR;
          irWrite = memReady;
          pcWrite = memReady;
        end
        S_DECODE: begin
          aluSrcB = SRCB_IMMSH;
          illegalOp = decode_target == S_FETCH;
        end
        S_MEMADR, S_ADDIEX: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          iorD = 1'b1;
          memRead = 1'b1;
        end
        S_MEMWB: begin
          regWrite = 1'b1;
          memToReg = WB_MEM;
        end
        S_MEMWR: begin
          iorD = 1'b1;
          memWrite = 1'b1;
        end
        S_EXEC: begin
          aluSrcA = 1'b1;
          aluControl = funct_ctrl;
        end
        S_ALUWB: begin
          regWrite = 1'b1;
          regDst = DST_RD;
        end
        S_BRANCH: begin
          aluSrcA = 1'b1;
          aluControl = ALU_SUB;
          pcSrc = PC_ALUOUT;
          pcWrite = zero;
        end
        S_ADDIWB: regWrite = 1'b1;
        S_JUMP: begin
          pcSrc = PC_JUMP;
          pcWrite = 1'b1;
          regWrite = opcode == OP_JAL;
          regDst = opcode == OP_JAL ? DST_RA : DST_RT;
          memToReg = opcode == OP_JAL ? WB_PC : WB_ALU;
        end
        S_JR: begin
          pcSrc = PC_RD1;
          pcWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: expands each instruction into its expected per-cycle control vectors and checks the sequencer against them
module tb_multicycle_control;
  typedef struct packed {
    logic       pcWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [4:0] aluControl;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic [1:0] pcSrc;
    logic       illegalOp;
  } vec_t;
  typedef struct packed {
    logic       rst;
    logic       mr;
    logic       zr;
    logic [5:0] op;
    logic [5:0] fn;
    logic       ret;
    vec_t       v;
  } ent_t;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic memReady = 1'b0;
  logic pcWrite, iorD, memRead, memWrite, irWrite, aluSrcA, regWrite, illegalOp;
  logic [1:0] aluSrcB, regDst, memToReg, pcSrc;
  logic [4:0] aluControl;
  logic [31:0] retired;
  vec_t got;
  ent_t q[$];
  ent_t cur;
  logic valid = 1'b0;
  logic [5:0] cur_op, cur_fn;
  logic cur_z;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int model_ret = 0;
  int mw_cnt = 0;
  int ill_cnt = 0;
  int wb_cnt = 0;
  multicycle_control dut (
    .clock(clk), .resetN(resetN), .opcode(opcode), .funct(funct), .zero(zero),
    .memReady(memReady), .pcWrite(pcWrite), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluControl(aluControl), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
    .pcSrc(pcSrc), .illegalOp(illegalOp), .retired(retired)
  );
  assign got = {pcWrite, iorD, memRead, memWrite, irWrite, aluSrcA, aluSrcB, aluControl,
                regWrite, regDst, memToReg, pcSrc, illegalOp};
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [4:0] alu_code(input logic [5:0] fn);
    case (fn)
      6'h22: return 5'b00001;
      6'h24: return 5'b00010;
      6'h25: return 5'b00011;
      6'h2A: return 5'b00100;
      default: return 5'b00000;
    endcase
  endfunction
  function automatic vec_t fetch_v(input logic mr);
    vec_t v = '0;
    v.memRead = 1'b1;
    v.aluSrcB = 2'b01;
    v.irWrite = mr;
    v.pcWrite = mr;
    return v;
  endfunction
  task automatic push(input logic rst, input logic mr, input logic ret, input vec_t v);
    ent_t e;
    e.rst = rst;
    e.mr = mr;
    e.zr = cur_z;
    e.op = cur_op;
    e.fn = cur_fn;
    e.ret = ret;
    e.v = v;
    q.push_back(e);
  endtask
  task automatic fetch_decode(input int fs, input logic bad);
    vec_t v;
    for (int i = 0; i < fs; i++) push(1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    push(1'b0, 1'b1, 1'b0, fetch_v(1'b1));
    v = '0;
    v.aluSrcB = 2'b11;
    v.illegalOp = bad;
    push(1'b0, 1'b0, 1'b0, v);
  endtask
  // whole-instruction model: fs fetch stalls, ms memory stalls
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fs, input int ms);
    vec_t v;
    logic is_alu, is_jr, bad;
    cur_op = op;
    cur_fn = fn;
    cur_z = z;
    is_alu = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
    is_jr = op == 6'h00 && fn == 6'h08;
    bad = !(is_alu || is_jr || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08 || op == 6'h02 || op == 6'h03);
    fetch_decode(fs, bad);
    if (op == 6'h23 || op == 6'h2B) begin
      v = '0;
      v.aluSrcA = 1'b1;
      v.aluSrcB = 2'b10;
      push(1'b0, 1'b0, 1'b0, v);
      v = '0;
      v.iorD = 1'b1;
      if (op == 6'h23) v.memRead = 1'b1;
      else v.memWrite = 1'b1;
      for (int i = 0; i < ms; i++) push(1'b0, 1'b0, 1'b0, v);
      push(1'b0, 1'b1, op == 6'h2B, v);
      if (op == 6'h23) begin
        v = '0;
        v.regWrite = 1'b1;
        v.memToReg = 2'b01;
        push(1'b0, 1'b0, 1'b1, v);
      end
    end else if (is_alu) begin
      v = '0;
      v.aluSrcA = 1'b1;
      v.aluControl = alu_code(fn);
      push(1'b0, 1'b0, 1'b0, v);
      v = '0;
      v.regWrite = 1'b1;
      v.regDst = 2'b01;
      push(1'b0, 1'b0, 1'b1, v);
    end else if (is_jr) begin
      v = '0;
      v.pcSrc = 2'b11;
      v.pcWrite = 1'b1;
      push(1'b0, 1'b0, 1'b1, v);
    end else if (op == 6'h04) begin
      v = '0;
      v.aluSrcA = 1'b1;
      v.aluControl = 5'b00001;
      v.pcSrc = 2'b01;
      v.pcWrite = z;
      push(1'b0, 1'b0, 1'b1, v);
    end else if (op == 6'h08) begin
      v = '0;
      v.aluSrcA = 1'b1;
      v.aluSrcB = 2'b10;
      push(1'b0, 1'b0, 1'b0, v);
      v = '0;
      v.regWrite = 1'b1;
      push(1'b0, 1'b0, 1'b1, v);
    end else if (op == 6'h02 || op == 6'h03) begin
      v = '0;
      v.pcSrc = 2'b10;
      v.pcWrite = 1'b1;
      if (op == 6'h03) begin
        v.regWrite = 1'b1;
        v.regDst = 2'b10;
        v.memToReg = 2'b10;
      end
      push(1'b0, 1'b0, 1'b1, v);
    end
  endtask
  // applies queued vectors one per cycle, then parks the DUT in FETCH with memReady low
  task automatic drain();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      resetN = !e.rst;
      memReady = e.mr;
      zero = e.zr;
      opcode = e.op;
      funct = e.fn;
      cur = e;
      valid = 1'b1;
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    memReady = 1'b0;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // per-cycle comparison against the queued expectation
  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      vectors++;
      if (got !== cur.v) begin
        miscompares++;
        $display("FAIL cycle %0d controls op=%h fn=%h: got %h, expected %h", cyc, cur.op, cur.fn, got, cur.v);
      end
      vectors++;
      if (retired !== (cur.rst ? 32'd0 : 32'(model_ret))) begin
        miscompares++;
        $display("FAIL cycle %0d retired: got %0d, expected %0d", cyc, retired, cur.rst ? 0 : model_ret);
      end
      if (cur.rst) model_ret = 0;
      else if (cur.ret) model_ret++;
      if (memWrite) mw_cnt++;
      if (illegalOp) ill_cnt++;
      if (regWrite && regDst == 2'b01) wb_cnt++;
    end
  end
  initial begin
    vec_t zv;
    zv = '0;
    cur_op = '0;
    cur_fn = '0;
    cur_z = 1'b0;
    push(1'b1, 1'b0, 1'b0, zv);
    push(1'b1, 1'b1, 1'b0, zv);
    instr(6'h23, 6'h00, 1'b0, 0, 0);
    drain();
    chk("lw retired", retired, 32'd1);
    mw_cnt = 0;
    instr(6'h2B, 6'h00, 1'b0, 0, 3);
    drain();
    chk("sw memWrite cycles", 32'(mw_cnt), 32'd4);
    chk("sw retired", retired, 32'd2);
    instr(6'h04, 6'h00, 1'b1, 0, 0);
    instr(6'h04, 6'h00, 1'b0, 0, 0);
    drain();
    chk("beq retired", retired, 32'd4);
    wb_cnt = 0;
    instr(6'h00, 6'h2A, 1'b0, 0, 0);
    instr(6'h00, 6'h20, 1'b0, 0, 0);
    instr(6'h00, 6'h22, 1'b0, 0, 0);
    instr(6'h00, 6'h24, 1'b1, 0, 0);
    instr(6'h00, 6'h25, 1'b0, 0, 0);
    instr(6'h00, 6'h08, 1'b0, 0, 0);
    drain();
    chk("R rd writebacks", 32'(wb_cnt), 32'd5);
    chk("R retired", retired, 32'd10);
    ill_cnt = 0;
    instr(6'h3F, 6'h00, 1'b0, 0, 0);
    instr(6'h00, 6'h3F, 1'b0, 0, 0);
    drain();
    chk("illegal pulses", 32'(ill_cnt), 32'd2);
    chk("illegal retired", retired, 32'd10);
    instr(6'h03, 6'h00, 1'b0, 0, 0);
    instr(6'h02, 6'h00, 1'b0, 1, 0);
    instr(6'h08, 6'h00, 1'b1, 0, 0);
    instr(6'h23, 6'h00, 1'b0, 2, 2);
    drain();
    chk("mixed retired", retired, 32'd14);
    cur_op = 6'h2B;
    cur_fn = 6'h00;
    cur_z = 1'b0;
    fetch_decode(0, 1'b0);
    zv = '0;
    zv.aluSrcA = 1'b1;
    zv.aluSrcB = 2'b10;
    push(1'b0, 1'b0, 1'b0, zv);
    zv = '0;
    zv.iorD = 1'b1;
    zv.memWrite = 1'b1;
    push(1'b0, 1'b0, 1'b0, zv);
    push(1'b0, 1'b0, 1'b0, zv);
    push(1'b1, 1'b0, 1'b0, '0);
    instr(6'h08, 6'h00, 1'b0, 0, 0);
    drain();
    chk("post-reset retired", retired, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state sequencer for the multicycle single-memory datapath. Consumes opcode/funct of the latched instruction plus ALU zero flag. Drives every datapath enable and mux select (PC write, IorD, IR write, ALU sources, ALU control, register write/destination, write-back select, PC source) one state at a time. Adds a memory-ready stall on every memory access, an illegal-opcode flag, and a retired-instruction counter.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU result == 0.
- memReady  in  1  combined memory has completed the current access this cycle.
- pcWrite  out  1  PC register enable.
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write enable.
- irWrite  out  1  instruction register enable.
- aluSrcA  out  1  0 = PC, 1 = register A.
- aluSrcB  out  2  00 = register B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- aluControl  out  5  ALU operation code.
- regWrite  out  1  register file WE3.
- regDst  out  2  00 = rt, 01 = rd, 10 = r31.
- memToReg  out  2  00 = ALUOut, 01 = memory data register, 10 = PC.
- pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = RD1.
- illegalOp  out  1  one-cycle pulse on an unsupported opcode or funct.
- retired  out  32  count of completed instructions.

## Operation
- Opcodes: R = 0x00, lw = 0x23, sw = 0x2B, beq = 0x04, addi = 0x08, j = 0x02, jal = 0x03. Funct values: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
- aluControl codes: ADD 00000, SUB 00001, AND 00010, OR 00011, SLT 00100.
- FETCH: iorD=0, memRead=1, aluSrcA=0, aluSrcB=01, ADD, pcSrc=00. irWrite and pcWrite equal memReady. On memReady, go to DECODE; otherwise hold.
- DECODE: aluSrcA=0, aluSrcB=11, ADD (branch target into ALUOut). Next state:
  - lw or sw: MEMADR.
  - R with funct jr: JR.
  - Other supported R: EXEC.
  - beq: BRANCH.
  - addi: ADDIEX.
  - j or jal: JUMP.
  - Anything else: illegalOp=1 and return to FETCH; retired does not count it.
- MEMADR: aluSrcA=1, aluSrcB=10, ADD. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: iorD=1, memRead=1. On memReady go to MEMWB; otherwise hold.
- MEMWB: regWrite=1, regDst=00, memToReg=01. Retire.
- MEMWR: iorD=1, memWrite=1. Hold until memReady, then retire.
- EXEC: aluSrcA=1, aluSrcB=00, aluControl from funct. Go to ALUWB.
- ALUWB: regWrite=1, regDst=01, memToReg=00. Retire.
- BRANCH: aluSrcA=1, aluSrcB=00, SUB, pcSrc=01, pcWrite=zero. Retire.
- ADDIEX: aluSrcA=1, aluSrcB=10, ADD. Go to ADDIWB.
- ADDIWB: regWrite=1, regDst=00, memToReg=00. Retire.
- JUMP: pcSrc=10, pcWrite=1. For jal also regWrite=1, regDst=10, memToReg=10. Retire.
- JR: pcSrc=11, pcWrite=1. Retire.
- "Retire" means: retired increments by 1, then go to FETCH. retired wraps from 0xFFFFFFFF to 0.
- Any output not listed for a state is 0.

## Timing
- Outputs are Moore, decoded from the state register. Exceptions are combinational:
  - irWrite and pcWrite in FETCH (gated by memReady).
  - pcWrite in BRANCH (from zero).
  - illegalOp in DECODE.
- Latency in cycles, with memReady tied high: lw 5, sw 4, R 4, addi 4, beq 3, j/jal/jr 3. Each cycle memReady is low adds one cycle in FETCH, MEMRD or MEMWR.
- memReady is sampled only in FETCH, MEMRD and MEMWR, and ignored elsewhere.
- Reset asserted: state = FETCH, retired = 0. All outputs forced 0, including memRead, regardless of state. This holds when reset is asserted mid-instruction; the partial instruction is abandoned, with no write or retire.
- First rising edge after reset deasserts performs FETCH.

## Structure
- Package multicycle_pkg holds:
  - the state enum;
  - opcode and funct localparams;
  - aluControl codes;
  - aluSrcB, regDst, memToReg and pcSrc encodings.
- Sub-module alu_decoder: combinational funct → aluControl, plus a funct-valid flag.

## Test plan
- Reset mid-MEMWR, with memReady=0 → memWrite drops immediately. After release: state FETCH, retired = 0, memRead = 1 on the first cycle.
- lw (opcode 0x23), memReady=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regWrite is seen only in cycle 5; retired = 1.
- sw with memReady low 3 cycles in MEMWR → memWrite held 4 cycles; total 7 cycles; iorD = 1 throughout MEMWR.
- beq with zero=1, then beq with zero=0 → pcWrite is 1 in the first BRANCH state and 0 in the second, with pcSrc=01 in both; each takes 3 cycles.
- R funct 0x2A → aluControl 00100 in EXEC; regDst 01 in ALUWB. R funct 0x08 → JR with pcSrc 11, no regWrite.
- Opcode 0x3F → illegalOp pulse in DECODE, back to FETCH next cycle, retired unchanged. jal → regDst 10, memToReg 10 with pcWrite=1.
